// File: rtl/laplacian_stream_filter_if.sv
// Stream interface for laplacian_stream_filter.
//
// Handshake semantics (both channels): a beat transfers on a rising clock
// edge where valid and ready are both high. A source holding valid high
// keeps its data stable until that edge. Ready may depend on downstream
// ready, but valid never depends on ready.
interface laplacian_stream_filter_if #(
    parameter int PIX_W = 8
);
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [PIX_W-1:0]        data_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic signed [PIX_W+3:0] data_o;
    logic                    frame_done_o;

    // Filter side
    modport slave (
        input  in_valid_i, data_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o, frame_done_o
    );

    // Pixel source / result sink side
    modport master (
        output in_valid_i, data_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o, frame_done_o
    );
endinterface

// File: rtl/laplacian_stream_filter.sv
// Streaming 3x3 Laplacian filter over raster-order pixels.
// Two line buffers feed a 3x3 window; each accepted pixel (r+1,c+1) completes
// the neighbourhood of interior centre (r,c), whose result is registered on
// the same edge. mode_i selects the 4-neighbour or 8-neighbour kernel.
// Optional feature: define LAPLACIAN_SAT_EN to clamp results to 0..2^PIX_W-1
// (zero-extended); otherwise the full signed result is output.
// fsm_state exposes the frame-tracking FSM (0 IDLE, 1 FILL, 2 RUN, 3 DONE).
module laplacian_stream_filter #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     mode_i,
    laplacian_stream_filter_if.slave bus,
    output logic [1:0]               fsm_state
);
    localparam int RES_W = PIX_W + 4;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Raster position of the next pixel to be accepted
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // line0 holds the previous row, line1 the row before that
    logic [PIX_W-1:0] line0 [IMG_W];
    logic [PIX_W-1:0] line1 [IMG_W];

    // win[row][col]: row 0 = oldest line, col 2 = most recent column
    logic [PIX_W-1:0] win [3][3];

    logic                    out_valid;
    logic                    out_last;
    logic signed [RES_W-1:0] out_data;

    logic in_ready;
    logic accept;
    logic out_take;
    logic centre_ok;
    logic last_pixel;
    logic frame_end;

    logic [PIX_W-1:0]        new_top;
    logic [PIX_W-1:0]        new_mid;
    logic [PIX_W-1:0]        new_bot;
    logic signed [RES_W-1:0] sum4;
    logic signed [RES_W-1:0] sum8;
    logic signed [RES_W-1:0] lap;
    logic signed [RES_W-1:0] res;

    function automatic logic signed [RES_W-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({4'b0000, p});
    endfunction

    assign in_ready   = en_i && (!out_valid || bus.out_ready_i);
    assign accept     = bus.in_valid_i && in_ready;
    assign out_take   = out_valid && bus.out_ready_i;
    assign centre_ok  = (row >= ROW_W'(2)) && (col >= COL_W'(2));
    assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);
    assign frame_end  = out_take && out_last;

    // Column arriving with the current pixel: rows r-2, r-1, r at column c
    assign new_top = line1[col];
    assign new_mid = line0[col];
    assign new_bot = bus.data_i;

    // Kernel on the neighbourhood completed by the incoming pixel; the centre
    // is the middle of the newest registered column
    always_comb begin
        sum4 = ext(win[0][2]) + ext(win[2][2]) + ext(win[1][1]) + ext(new_mid);
        sum8 = sum4 + ext(win[0][1]) + ext(win[2][1]) + ext(new_top) + ext(new_bot);
        if (mode_i) begin
            lap = sum8 - (ext(win[1][2]) <<< 3);
        end else begin
            lap = sum4 - (ext(win[1][2]) <<< 2);
        end
    end

`ifdef LAPLACIAN_SAT_EN
    localparam logic signed [RES_W-1:0] PIX_MAX = RES_W'((1 << PIX_W) - 1);

    // Clamp to the unsigned pixel range
    always_comb begin
        res = lap;
        if (lap[RES_W-1]) begin
            res = '0;
        end else if (lap > PIX_MAX) begin
            res = PIX_MAX;
        end
    end
`else
    assign res = lap;
`endif

    // Raster counters step once per accepted pixel and wrap at frame end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line buffers shift the column down one line per accepted pixel;
    // no reset, rows 0-1 of every frame overwrite them before use
    always_ff @(posedge clk_i) begin
        if (accept) begin
            line1[col] <= line0[col];
            line0[col] <= bus.data_i;
        end
    end

    // Window shifts left and takes the new column on each accepted pixel
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= new_top;
            win[1][2] <= new_mid;
            win[2][2] <= new_bot;
        end
    end

    // Result register: loads on accepted pixels that complete an interior
    // centre, clears when taken, otherwise holds (stable under back-pressure)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (accept && centre_ok) begin
            out_valid <= 1'b1;
            out_last  <= last_pixel;
            out_data  <= res;
        end else if (out_take) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: FILL until pixel (2,1) arrives, RUN until the final
    // result is taken, then a single DONE cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (en_i) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (accept && (row == ROW_W'(2)) && (col == COL_W'(1))) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (frame_end) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = FILL;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.in_ready_o   = in_ready;
    assign bus.out_valid_o  = out_valid;
    assign bus.data_o       = out_data;
    assign bus.frame_done_o = (state == DONE);
    assign fsm_state        = state;
endmodule

// File: tb/tb_laplacian_stream_filter.sv
// Bench for laplacian_stream_filter on a 12x10 frame.
// Frames are pushed pixel by pixel; the expected result for each interior
// centre is queued when its completing pixel is issued, and a monitor pops
// and compares on every output beat.
module tb_laplacian_stream_filter;
    localparam int PIX_W = 8;
    localparam int IMG_W = 12;
    localparam int IMG_H = 10;
    localparam int RES_W = PIX_W + 4;
    localparam int N_RES = (IMG_W - 2) * (IMG_H - 2);
    localparam int NEVER = 1 << 30;

    localparam int K_FLAT    = 0;
    localparam int K_IMPULSE = 1;
    localparam int K_RAMP    = 2;
    localparam int K_MODEL   = 3;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic [1:0] fsm_state;

    always #5 clk = ~clk;

    laplacian_stream_filter_if #(.PIX_W(PIX_W)) bus ();

    laplacian_stream_filter #(
        .PIX_W(PIX_W),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .mode_i    (mode),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    logic [RES_W-1:0] exp_q[$];
    bit               last_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int results_seen = 0;
    int done_seen = 0;
    int stall_mode = 0;
    bit done_pending = 1'b0;
    int img [IMG_H][IMG_W];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int sat(input int v);
`ifdef LAPLACIAN_SAT_EN
        if (v < 0) return 0;
        if (v > (1 << PIX_W) - 1) return (1 << PIX_W) - 1;
`endif
        return v;
    endfunction

    // Plain 2-D convolution over the stored frame
    function automatic int ref_lap(input int r, input int c, input int m);
        int s = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0) && !(m == 0 && dr != 0 && dc != 0))
                    s += img[r+dr][c+dc];
            end
        end
        return s - ((m != 0) ? 8 : 4) * img[r][c];
    endfunction

    // Hand-derived results for the directed frames
    function automatic int exp_val(input int kind, input int r, input int c, input int m);
        int dr;
        int dc;
        dr = r - 5;
        dc = c - 5;
        case (kind)
            K_FLAT, K_RAMP: return 0;
            K_IMPULSE: begin
                if (dr == 0 && dc == 0) return (m != 0) ? -2040 : -1020;
                if (dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1) begin
                    if (m != 0 || dr == 0 || dc == 0) return 255;
                    return 0;
                end
                return 0;
            end
            default: return ref_lap(r, c, m);
        endcase
    endfunction

    task automatic fill_image(input int kind);
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                case (kind)
                    K_FLAT:    img[r][c] = 100;
                    K_IMPULSE: img[r][c] = (r == 5 && c == 5) ? 255 : 0;
                    K_RAMP:    img[r][c] = c;
                    default:   img[r][c] = (r * 37 + c * 91 + r * c * 13) % 256;
                endcase
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_pixel(input int val, input int m);
        int budget = 0;
        bus.in_valid_i = 1'b1;
        bus.data_i     = PIX_W'(val);
        mode           = m[0];
        forever begin
            @(negedge clk);
            if (bus.in_ready_o) break;
            budget++;
            if (budget > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", budget);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic do_pause();
        logic [1:0] st;
        en = 1'b0;
        st = fsm_state;
        repeat (4) begin
            @(negedge clk);
            check("pause_in_ready", bus.in_ready_o, 0);
            check("pause_state", fsm_state, st);
        end
        @(posedge clk);
        #1;
        en = 1'b1;
    endtask

    task automatic drive_frame(input int kind, input int m0, input int m1,
                               input int switch_at, input int pause_at, input int stop_at);
        int idx = 0;
        int m;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (idx == stop_at) return;
                if (idx == pause_at) do_pause();
                m = (idx >= switch_at) ? m1 : m0;
                if (r >= 2 && c >= 2) begin
                    exp_q.push_back(RES_W'(sat(exp_val(kind, r - 1, c - 1, m))));
                    last_q.push_back(r == IMG_H - 1 && c == IMG_W - 1);
                end
                send_pixel(img[r][c], m);
                if (r == 2 && c == 1) check("state_run", fsm_state, 2);
                idx++;
            end
        end
    endtask

    task automatic finish_frame(input int s0, input int d0);
        int budget = 0;
        while ((exp_q.size() != 0 || bus.out_valid_o) && budget < 500) begin
            @(posedge clk);
            budget++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("result_count", results_seen - s0, N_RES);
        check("frame_done_count", done_seen - d0, 1);
        check("queue_empty", exp_q.size(), 0);
        check("state_fill", fsm_state, 1);
    endtask

    task automatic run_frame(input int kind, input int m0, input int m1,
                             input int switch_at, input int pause_at);
        int s0;
        int d0;
        s0 = results_seen;
        d0 = done_seen;
        fill_image(kind);
        drive_frame(kind, m0, m1, switch_at, pause_at, NEVER);
        finish_frame(s0, d0);
    endtask

    // ---------------- downstream ready pattern ----------------
    initial begin : ready_gen
        int cyc;
        cyc = 0;
        bus.out_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.out_ready_i = (stall_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic signed [RES_W-1:0] held;
        logic [RES_W-1:0]        e;
        bit                      lst;
        bit                      stalled;
        held = '0;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
                done_pending = 1'b0;
            end else begin
                if (done_pending || bus.frame_done_o)
                    check("frame_done", bus.frame_done_o, done_pending);
                if (bus.frame_done_o) done_seen++;
                if (stalled) begin
                    check("hold_valid", bus.out_valid_o, 1);
                    check("hold_data", $signed(bus.data_o), held);
                end
                stalled = bus.out_valid_o && !bus.out_ready_i;
                held = bus.data_o;
                done_pending = 1'b0;
                if (bus.out_valid_o && bus.out_ready_i) begin
                    results_seen++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL result: unexpected output %0d, required none", $signed(bus.data_o));
                    end else begin
                        e = exp_q.pop_front();
                        lst = last_q.pop_front();
                        check("result", $signed(bus.data_o), $signed(e));
                        done_pending = lst;
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        en = 1'b0;
        mode = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.data_i = '0;
        #2;
        check("rst_out_valid", bus.out_valid_o, 0);
        check("rst_data", $signed(bus.data_o), 0);
        check("rst_frame_done", bus.frame_done_o, 0);
        check("rst_in_ready_en0", bus.in_ready_o, 0);
        check("rst_state", fsm_state, 0);
        en = 1'b1;
        #1;
        check("rst_in_ready_en1", bus.in_ready_o, 1);
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        en = 1'b1;

        // Directed frames, always-ready sink
        run_frame(K_FLAT, 0, 0, NEVER, NEVER);
        run_frame(K_IMPULSE, 1, 1, NEVER, NEVER);
        run_frame(K_IMPULSE, 0, 0, NEVER, NEVER);
        run_frame(K_RAMP, 0, 0, NEVER, NEVER);
        run_frame(K_RAMP, 1, 1, NEVER, NEVER);

        // Enable dropped mid-frame, mode switched mid-frame
        run_frame(K_MODEL, 0, 1, 61, 40);

        // Sink ready one cycle in three
        stall_mode = 1;
        run_frame(K_FLAT, 0, 0, NEVER, NEVER);
        run_frame(K_MODEL, 1, 0, 50, 70);
        stall_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of an impulse frame, then a clean frame
        fill_image(K_IMPULSE);
        drive_frame(K_IMPULSE, 1, 1, NEVER, NEVER, 6 * IMG_W);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid_o, 0);
        check("midrst_state", fsm_state, 0);
        exp_q.delete();
        last_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame(K_IMPULSE, 1, 1, NEVER, NEVER);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
